br_resolve: RTL and testbench
=============================

BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width in bits (at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the request is valid.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a request.
REQ-007 SHALL have port rs, input, DATA_W, first operand.
REQ-008 SHALL have port rt, input, DATA_W, second operand; ignored by single-operand ops.
REQ-009 SHALL have port br_op, input, 3, branch condition code (see REQ-015).
REQ-010 SHALL have port pred_taken, input, 1, the front-end prediction for this branch.
REQ-011 SHALL have port flush, input, 1, discards any held result.
REQ-012 SHALL have outputs out_valid (1) and out_ready (input, 1), the downstream handshake.
REQ-013 SHALL have outputs taken (1) and mispredict (1), held with out_valid.
REQ-014 SHALL have outputs br_cnt (CNT_W) and mp_cnt (CNT_W), statistics counters.

Function
REQ-015 SHALL decode br_op as follows; rs and rt are two's complement unless marked unsigned:
- 0 EQ: rs==rt
- 1 NE: rs!=rt
- 2 LEZ: rs<=0
- 3 GTZ: rs>0
- 4 LTZ: rs<0
- 5 GEZ: rs>=0
- 6 LT: rs<rt, signed
- 7 LTU: rs<rt, unsigned
REQ-016 SHALL compute the sign and zero tests over all DATA_W bits, with the sign taken from bit DATA_W-1.
REQ-017 SHALL form the signed LT compare without overflow error, using a DATA_W+1-bit compare or an MSB-select.
REQ-018 SHALL hold one result register: it loads taken = condition and mispredict = condition XOR pred_taken when in_valid && in_ready, and does not flush.
REQ-019 SHALL give a latency of 1 cycle: the result is visible on out_valid the cycle after acceptance.
REQ-020 SHALL drive in_ready = !out_valid || out_ready, so back-to-back requests with no bubbles are supported.
REQ-021 SHALL keep out_valid, taken and mispredict stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid when the result is consumed (out_valid && out_ready) with no new acceptance in the same cycle.
REQ-023 SHALL give flush priority: out_valid goes 0 next cycle and any same-cycle input handshake is dropped; counters do not change for a flushed entry.
REQ-024 SHALL increment br_cnt on each consumption.
REQ-025 SHALL increment mp_cnt on each consumption with mispredict=1.
REQ-026 SHALL saturate both counters at all-ones, with no wrap-around.
REQ-027 SHALL not gate taken and mispredict with out_valid; consumers qualify them with out_valid.

Reset
REQ-028 SHALL, while resetn=0, drive out_valid=0, taken=0, mispredict=0, br_cnt=0 and mp_cnt=0.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset.
REQ-030 SHALL discard, on reset in mid-operation, a held result without counting it.

Structure
REQ-031 SHALL place the br_op encodings (the eight 3-bit localparam constants) in a shared package, br_pkg, which the decoder also uses.
REQ-032 SHALL implement the condition evaluation as one combinational sub-module, br_cond, with parameter DATA_W, inputs rs, rt and br_op, and output cond.
REQ-033 SHALL implement the handshake register and counters in br_resolve.

Verification
REQ-034 SHALL cover: EQ with rs=rt=0x1234_5678, pred_taken=0 -> next cycle out_valid=1, taken=1, mispredict=1; after consumption mp_cnt=1 and br_cnt=1.
REQ-035 SHALL cover: LT with rs=0x8000_0000, rt=0x0000_0001 -> taken=1; LTU with the same operands -> taken=0.
REQ-036 SHALL cover: all 8 ops with rs in {0, 1, 0xFFFF_FFFF, 0x7FFF_FFFF, 0x8000_0000} and rt=rs or rt=rs+1 -> matches the reference model.
REQ-037 SHALL cover: out_ready=0 for 3 cycles while a result is held -> in_ready=0, outputs stable, no counter change; out_ready=1 -> one count only.
REQ-038 SHALL cover: flush asserted in the same cycle as an input handshake, while holding a result -> out_valid=0 next cycle and counters unchanged.
REQ-039 SHALL cover: CNT_W=2 with 5 consumed mispredicts -> br_cnt=3 and mp_cnt=3 (saturated); resetn pulse -> both 0.

Source files
------------

// File: rtl/br_pkg.sv
// Branch condition encodings shared by the decoder and its users.
package br_pkg;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_GTZ = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;
  localparam logic [2:0] BR_LT  = 3'd6;
  localparam logic [2:0] BR_LTU = 3'd7;

endpackage

// File: rtl/br_resolve_if.sv
// Request/result bus of the branch resolver; master drives requests, slave is the resolver.
interface br_resolve_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [2:0]        br_op;
  logic              pred_taken;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              taken;
  logic              mispredict;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  mp_cnt;

  modport master (
    output in_valid, rs, rt, br_op, pred_taken, flush, out_ready,
    input  in_ready, out_valid, taken, mispredict, br_cnt, mp_cnt
  );

  modport slave (
    input  in_valid, rs, rt, br_op, pred_taken, flush, out_ready,
    output in_ready, out_valid, taken, mispredict, br_cnt, mp_cnt
  );

endinterface

// File: rtl/br_cond.sv
// Combinational branch condition evaluation over two DATA_W-bit operands.
module br_cond
  import br_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [2:0]        br_op,
  output logic              cond
);

  logic w_rs_neg;
  logic w_rs_zero;
  logic w_lt_u;
  logic w_lt_s;

  assign w_rs_neg  = rs[DATA_W-1];
  assign w_rs_zero = (rs == {DATA_W{1'b0}});
  assign w_lt_u    = (rs < rt);
  // Differing signs decide the signed order directly; equal signs fall back to the unsigned compare.
  assign w_lt_s    = (rs[DATA_W-1] != rt[DATA_W-1]) ? rs[DATA_W-1] : w_lt_u;

  // Select the condition for the requested branch op.
  always_comb begin
    cond = 1'b0;
    case (br_op)
      BR_EQ:   cond = (rs == rt);
      BR_NE:   cond = (rs != rt);
      BR_LEZ:  cond = w_rs_neg | w_rs_zero;
      BR_GTZ:  cond = ~w_rs_neg & ~w_rs_zero;
      BR_LTZ:  cond = w_rs_neg;
      BR_GEZ:  cond = ~w_rs_neg;
      BR_LT:   cond = w_lt_s;
      BR_LTU:  cond = w_lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve.sv
// Branch resolver: one-deep result register with valid/ready handshake,
// flush, and saturating branch/mispredict statistics.
module br_resolve #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           resetn,
  br_resolve_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_cond;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_consume;
  logic             r_out_valid;
  logic             r_taken;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  br_cond #(
    .DATA_W (DATA_W)
  ) u_cond (
    .rs    (bus.rs),
    .rt    (bus.rt),
    .br_op (bus.br_op),
    .cond  (w_cond)
  );

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_consume  = r_out_valid & bus.out_ready;

  // Result register and statistics; flush drops both the held result and any new request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_br_cnt     <= {CNT_W{1'b0}};
      r_mp_cnt     <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_taken      <= w_cond;
        r_mispredict <= w_cond ^ bus.pred_taken;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      if (w_consume && (r_br_cnt != CNT_MAX)) begin
        r_br_cnt <= r_br_cnt + CNT_ONE;
      end
      if (w_consume && r_mispredict && (r_mp_cnt != CNT_MAX)) begin
        r_mp_cnt <= r_mp_cnt + CNT_ONE;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.taken      = r_taken;
  assign bus.mispredict = r_mispredict;
  assign bus.br_cnt     = r_br_cnt;
  assign bus.mp_cnt     = r_mp_cnt;

endmodule

// File: tb/tb_br_resolve.sv
// Random + directed bench for br_resolve; two instances (16-bit and 2-bit counters)
// receive identical stimulus and are compared against a transaction-level model.
module tb_br_resolve;

  localparam int DW = 32;

  logic clk;
  logic resetn;

  br_resolve_if #(.DATA_W(DW), .CNT_W(16)) bus_a ();
  br_resolve_if #(.DATA_W(DW), .CNT_W(2))  bus_b ();

  br_resolve #(.DATA_W(DW), .CNT_W(16)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  br_resolve #(.DATA_W(DW), .CNT_W(2))  dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: held result and unbounded consumption counts.
  bit m_valid;
  bit m_taken;
  bit m_mp;
  int m_br;
  int m_mp_cnt;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint as_signed(input logic [DW-1:0] v);
    return v[DW-1] ? (longint'(v) - 64'sh1_0000_0000) : longint'(v);
  endfunction

  function automatic bit ref_cond(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa = as_signed(a);
    longint sb = as_signed(b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (op)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd2:    return sa <= 64'sd0;
      3'd3:    return sa > 64'sd0;
      3'd4:    return sa < 64'sd0;
      3'd5:    return sa >= 64'sd0;
      3'd6:    return sa < sb;
      default: return ua < ub;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] op, input bit pt, input bit fl, input bit ordy);
    bus_a.in_valid = v;  bus_b.in_valid = v;
    bus_a.rs = a;        bus_b.rs = a;
    bus_a.rt = b;        bus_b.rt = b;
    bus_a.br_op = op;    bus_b.br_op = op;
    bus_a.pred_taken = pt; bus_b.pred_taken = pt;
    bus_a.flush = fl;    bus_b.flush = fl;
    bus_a.out_ready = ordy; bus_b.out_ready = ordy;
  endtask

  task automatic check_outputs(input string tag);
    chk_val({tag, ".ov_a"}, 64'(bus_a.out_valid), 64'(m_valid));
    chk_val({tag, ".ov_b"}, 64'(bus_b.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk_val({tag, ".tk_a"}, 64'(bus_a.taken), 64'(m_taken));
      chk_val({tag, ".mp_a"}, 64'(bus_a.mispredict), 64'(m_mp));
      chk_val({tag, ".tk_b"}, 64'(bus_b.taken), 64'(m_taken));
    end
    chk_val({tag, ".brc_a"}, 64'(bus_a.br_cnt), 64'(sat(m_br, 65535)));
    chk_val({tag, ".mpc_a"}, 64'(bus_a.mp_cnt), 64'(sat(m_mp_cnt, 65535)));
    chk_val({tag, ".brc_b"}, 64'(bus_b.br_cnt), 64'(sat(m_br, 3)));
    chk_val({tag, ".mpc_b"}, 64'(bus_b.mp_cnt), 64'(sat(m_mp_cnt, 3)));
  endtask

  // One clock: apply inputs, check in_ready, advance model, check registered outputs.
  task automatic cycle(input string tag, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] op, input bit pt, input bit fl, input bit ordy);
    bit rdy, acc, cons, c;
    drive(v, a, b, op, pt, fl, ordy);
    #1;
    rdy = !m_valid || ordy;
    chk_val({tag, ".ir_a"}, 64'(bus_a.in_ready), 64'(rdy));
    chk_val({tag, ".ir_b"}, 64'(bus_b.in_ready), 64'(rdy));
    acc  = v && rdy;
    cons = m_valid && ordy;
    c    = ref_cond(op, a, b);
    @(posedge clk);
    #1;
    if (fl) begin
      m_valid = 1'b0;
    end else begin
      if (cons) begin
        m_br++;
        if (m_mp) m_mp_cnt++;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_taken = c;
        m_mp    = c ^ pt;
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
    check_outputs(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    #2;
    m_valid = 1'b0; m_taken = 1'b0; m_mp = 1'b0; m_br = 0; m_mp_cnt = 0;
    chk_val("rst.ov_a", 64'(bus_a.out_valid), 64'd0);
    chk_val("rst.tk_a", 64'(bus_a.taken), 64'd0);
    chk_val("rst.mp_a", 64'(bus_a.mispredict), 64'd0);
    chk_val("rst.brc_a", 64'(bus_a.br_cnt), 64'd0);
    chk_val("rst.mpc_a", 64'(bus_a.mp_cnt), 64'd0);
    chk_val("rst.brc_b", 64'(bus_b.br_cnt), 64'd0);
    chk_val("rst.mpc_b", 64'(bus_b.mp_cnt), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk_val("rst.ir_a", 64'(bus_a.in_ready), 64'd1);
  endtask

  logic [DW-1:0] edge_vals [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

  initial begin
    resetn = 1'b1;
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    #3;
    do_reset();

    // EQ predicted not-taken -> taken and mispredicted, then consumed once.
    cycle("eq", 1'b1, 32'h1234_5678, 32'h1234_5678, 3'd0, 1'b0, 1'b0, 1'b1);
    chk_val("eq.taken", 64'(bus_a.taken), 64'd1);
    chk_val("eq.misp",  64'(bus_a.mispredict), 64'd1);
    cycle("eq_cons", 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk_val("eq.brc", 64'(bus_a.br_cnt), 64'd1);
    chk_val("eq.mpc", 64'(bus_a.mp_cnt), 64'd1);

    // Signed vs unsigned less-than on a sign-boundary operand.
    cycle("lt",  1'b1, 32'h8000_0000, 32'h0000_0001, 3'd6, 1'b1, 1'b0, 1'b1);
    chk_val("lt.taken", 64'(bus_a.taken), 64'd1);
    cycle("ltu", 1'b1, 32'h8000_0000, 32'h0000_0001, 3'd7, 1'b1, 1'b0, 1'b1);
    chk_val("ltu.taken", 64'(bus_a.taken), 64'd0);

    // Backpressure: three stalled cycles with a competing request, then one drain.
    for (int i = 0; i < 3; i++)
      cycle("stall", 1'b1, 32'd5, 32'd5, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle("drain", 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    cycle("idle",  1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Flush while holding, coinciding with a new handshake.
    cycle("hold",  1'b1, 32'd3, 32'd4, 3'd6, 1'b0, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'd3, 32'd3, 3'd0, 1'b0, 1'b1, 1'b1);
    cycle("post_flush", 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Edge-value sweep over all ops, back to back.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 2; j++)
        for (int op = 0; op < 8; op++)
          cycle("sweep", 1'b1, edge_vals[i], edge_vals[i] + 32'(j), 3'(op), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    cycle("sweep_end", 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Reset in mid-operation discards the held result.
    cycle("pre_rst", 1'b1, 32'd1, 32'd2, 3'd0, 1'b1, 1'b0, 1'b0);
    do_reset();
    cycle("after_rst", 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Five consumed mispredicts saturate the 2-bit counters.
    for (int i = 0; i < 5; i++)
      cycle("satq", 1'b1, 32'd7, 32'd7, 3'd0, 1'b0, 1'b0, 1'b1);
    cycle("sat_end", 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk_val("sat.brc_b", 64'(bus_b.br_cnt), 64'd3);
    chk_val("sat.mpc_b", 64'(bus_b.mp_cnt), 64'd3);
    chk_val("sat.brc_a", 64'(bus_a.br_cnt), 64'd5);
    do_reset();
    chk_val("sat_rst.brc_b", 64'(bus_b.br_cnt), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 2);
      a = (sel == 0) ? edge_vals[$urandom_range(0, 4)] : DW'($urandom);
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? a : (sel == 1) ? a + 32'd1 : DW'($urandom);
      cycle("rand", $urandom_range(0, 3) != 0, a, b, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
